// File: rtl/serial_frame_seq.sv
// rtl/serial_frame_seq.sv - frame sequencer driving the 7-way serial bit-select mux
module serial_frame_seq #(
    parameter int         BIT_CYCLES = 4,
    parameter logic [7:0] THRESH     = 8'h80
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] data_h,
    input  logic [3:0] data_l,
    output logic [2:0] muxsel,
    output logic       thrsh,
    output logic       regh_b0,
    output logic       regh_b2,
    output logic       regl_b0,
    output logic       regl_b2,
    output logic       busy,
    output logic       done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_FLAG  = 3'd2;
    localparam logic [2:0] S_HIGH  = 3'd3;
    localparam logic [2:0] S_LOW   = 3'd4;
    localparam logic [2:0] S_STOP  = 3'd5;

    localparam logic [7:0] LAST_TICK = 8'(BIT_CYCLES - 1);

    logic [2:0] r_state;
    logic [2:0] w_next_state;
    logic [7:0] r_timer;
    logic [1:0] r_idx;
    logic [3:0] r_regh;
    logic [3:0] r_regl;
    logic [2:0] r_muxsel;
    logic       r_thrsh;
    logic       r_busy;
    logic       r_done;
    logic       w_tick_end;
    logic       w_accept;

    assign w_tick_end = (r_state != S_IDLE) && (r_timer == LAST_TICK);
    assign w_accept   = (r_state == S_IDLE) && start;

    // Select code for the symbol that the next state puts on the line.
    function automatic logic [2:0] sel_code(input logic [2:0] st);
        case (st)
            S_START: sel_code = 3'b000;
            S_FLAG:  sel_code = 3'b010;
            S_HIGH:  sel_code = 3'b011;
            S_LOW:   sel_code = 3'b100;
            default: sel_code = 3'b001;
        endcase
    endfunction

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next_state = S_START;
            S_START: if (w_tick_end) w_next_state = S_FLAG;
            S_FLAG:  if (w_tick_end) w_next_state = S_HIGH;
            S_HIGH:  if (w_tick_end && (r_idx == 2'd3)) w_next_state = S_LOW;
            S_LOW:   if (w_tick_end && (r_idx == 2'd3)) w_next_state = S_STOP;
            S_STOP:  if (w_tick_end) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_timer  <= 8'd0;
            r_idx    <= 2'd0;
            r_regh   <= 4'd0;
            r_regl   <= 4'd0;
            r_muxsel <= 3'b001;
            r_thrsh  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_muxsel <= sel_code(w_next_state);
            r_busy   <= (w_next_state != S_IDLE);
            r_done   <= (r_state == S_STOP) && w_tick_end;

            if ((r_state == S_IDLE) || w_tick_end) begin
                r_timer <= 8'd0;
            end else begin
                r_timer <= r_timer + 8'd1;
            end

            // The 2-bit index wraps back to 0 after the fourth symbol of each nibble.
            if (w_tick_end && ((r_state == S_HIGH) || (r_state == S_LOW))) begin
                r_idx <= r_idx + 2'd1;
            end

            if (w_accept) begin
                r_regh  <= data_h;
                r_regl  <= data_l;
                r_thrsh <= ({data_h, data_l} >= THRESH);
            end

            if (w_tick_end && (r_state == S_HIGH)) begin
                r_regh <= {1'b0, r_regh[3:1]};
            end
            if (w_tick_end && (r_state == S_LOW)) begin
                r_regl <= {1'b0, r_regl[3:1]};
            end
        end
    end

    assign muxsel  = r_muxsel;
    assign thrsh   = r_thrsh;
    assign busy    = r_busy;
    assign done    = r_done;
    assign regh_b0 = r_regh[0];
    assign regh_b2 = r_regh[2];
    assign regl_b0 = r_regl[0];
    assign regl_b2 = r_regl[2];

endmodule

// File: tb/tb_serial_frame_seq.sv
// tb/tb_serial_frame_seq.sv - directed and randomized frame checks against a symbol-level model
module tb_serial_frame_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_r = 1'b0;
    logic       dut_sel = 1'b0;
    logic [3:0] dh = 4'd0;
    logic [3:0] dl = 4'd0;

    logic       start1, start2;
    logic [2:0] mux1, mux2;
    logic       thr1, hb01, hb21, lb01, lb21, busy1, done1;
    logic       thr2, hb02, hb22, lb02, lb22, busy2, done2;

    logic [2:0] o_mux;
    logic       o_thr, o_hb0, o_hb2, o_lb0, o_lb2, o_busy, o_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign start1 = start_r & ~dut_sel;
    assign start2 = start_r & dut_sel;

    serial_frame_seq #(.BIT_CYCLES(4), .THRESH(8'h80)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start1), .data_h(dh), .data_l(dl),
        .muxsel(mux1), .thrsh(thr1), .regh_b0(hb01), .regh_b2(hb21),
        .regl_b0(lb01), .regl_b2(lb21), .busy(busy1), .done(done1)
    );

    serial_frame_seq #(.BIT_CYCLES(2), .THRESH(8'h80)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .data_h(dh), .data_l(dl),
        .muxsel(mux2), .thrsh(thr2), .regh_b0(hb02), .regh_b2(hb22),
        .regl_b0(lb02), .regl_b2(lb22), .busy(busy2), .done(done2)
    );

    always_comb begin
        o_mux  = dut_sel ? mux2  : mux1;
        o_thr  = dut_sel ? thr2  : thr1;
        o_hb0  = dut_sel ? hb02  : hb01;
        o_hb2  = dut_sel ? hb22  : hb21;
        o_lb0  = dut_sel ? lb02  : lb01;
        o_lb2  = dut_sel ? lb22  : lb21;
        o_busy = dut_sel ? busy2 : busy1;
        o_done = dut_sel ? done2 : done1;
    end

    // External 7-way mux as seen on the serial line.
    function automatic logic line_of(input logic [2:0] sel, input logic t, input logic h0, input logic l0);
        case (sel)
            3'b000:  line_of = 1'b0;
            3'b001:  line_of = 1'b1;
            3'b010:  line_of = t;
            3'b011:  line_of = h0;
            3'b100:  line_of = l0;
            default: line_of = 1'bx;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string name);
        chk({name, ".mux"},  {5'd0, o_mux}, 8'd1);
        chk({name, ".busy"}, {7'd0, o_busy}, 8'd0);
        chk({name, ".done"}, {7'd0, o_done}, 8'd0);
    endtask

    // Drives one start and checks every cycle of the frame plus the done cycle.
    task automatic frame_check(input logic [3:0] h, input logic [3:0] l, input int bc,
                               input bit inj, input bit hold, input string name);
        logic       sym [11];
        logic       flag;
        logic [7:0] v;
        logic [2:0] e_mux;
        logic [3:0] eh, el;
        logic       e_line, e_busy, e_done;
        int         n, s;
        v    = {h, l};
        flag = (v >= 8'h80);
        sym[0]  = 1'b0;
        sym[1]  = flag;
        for (int i = 0; i < 4; i++) begin
            sym[2 + i] = h[i];
            sym[6 + i] = l[i];
        end
        sym[10] = 1'b1;
        n = 11 * bc;
        dh = h;
        dl = l;
        start_r = 1'b1;
        @(posedge clk);
        #1 start_r = hold;
        for (int t = 1; t <= n + 1; t++) begin
            @(negedge clk);
            if (t == n + 1) begin
                e_mux = 3'b001; e_busy = 1'b0; e_done = 1'b1; e_line = 1'b1;
                eh = 4'd0; el = 4'd0;
            end else begin
                s = (t - 1) / bc;
                e_busy = 1'b1; e_done = 1'b0; e_line = sym[s];
                if (s == 0)       e_mux = 3'b000;
                else if (s == 1)  e_mux = 3'b010;
                else if (s < 6)   e_mux = 3'b011;
                else if (s < 10)  e_mux = 3'b100;
                else              e_mux = 3'b001;
                eh = (s < 2) ? h : (s < 6) ? (h >> (s - 2)) : 4'd0;
                el = (s < 6) ? l : (s < 10) ? (l >> (s - 6)) : 4'd0;
            end
            chk($sformatf("%s.mux t=%0d", name, t),  {5'd0, o_mux}, {5'd0, e_mux});
            chk($sformatf("%s.line t=%0d", name, t), {7'd0, line_of(o_mux, o_thr, o_hb0, o_lb0)}, {7'd0, e_line});
            chk($sformatf("%s.busy t=%0d", name, t), {7'd0, o_busy}, {7'd0, e_busy});
            chk($sformatf("%s.done t=%0d", name, t), {7'd0, o_done}, {7'd0, e_done});
            chk($sformatf("%s.thrsh t=%0d", name, t), {7'd0, o_thr}, {7'd0, flag});
            chk($sformatf("%s.taps t=%0d", name, t), {4'd0, o_hb2, o_hb0, o_lb2, o_lb0},
                {4'd0, eh[2], eh[0], el[2], el[0]});
            if (t <= n) begin
                @(posedge clk);
                #1;
                if (inj && (t == 4 || t == 29)) begin
                    start_r = 1'b1;
                    dh = 4'($urandom);
                    dl = 4'($urandom);
                end else if (!hold) begin
                    start_r = 1'b0;
                end
            end
        end
    endtask

    task automatic idle_cycles(input int n);
        start_r = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_idle("reset");
        chk("reset.thrsh", {7'd0, thr1}, 8'd0);
        chk("reset.taps", {4'd0, hb21, hb01, lb21, lb01}, 8'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk_idle("post_reset");

        frame_check(4'hA, 4'h3, 4, 1'b0, 1'b0, "nominal");
        idle_cycles(2);
        frame_check(4'h8, 4'h0, 4, 1'b0, 1'b0, "thr80");
        idle_cycles(1);
        frame_check(4'h7, 4'hF, 4, 1'b0, 1'b0, "thr7f");
        idle_cycles(3);
        frame_check(4'h5, 4'hC, 4, 1'b1, 1'b0, "blocked");
        @(negedge clk);
        chk_idle("blocked.after");

        idle_cycles(1);
        frame_check(4'($urandom), 4'($urandom), 4, 1'b0, 1'b1, "b2b0");
        frame_check(4'($urandom), 4'($urandom), 4, 1'b0, 1'b1, "b2b1");
        frame_check(4'($urandom), 4'($urandom), 4, 1'b0, 1'b0, "b2b2");

        idle_cycles(2);
        dut_sel = 1'b1;
        frame_check(4'b0100, 4'($urandom), 2, 1'b0, 1'b0, "taps");
        idle_cycles(1);
        frame_check(4'($urandom), 4'($urandom), 2, 1'b0, 1'b0, "rnd_bc2");
        idle_cycles(2);
        dut_sel = 1'b0;

        for (int i = 0; i < 4; i++) begin
            frame_check(4'($urandom), 4'($urandom), 4, 1'b0, 1'b0, $sformatf("rnd%0d", i));
            idle_cycles(1 + i);
        end

        // Asynchronous reset in cycle k+10, inside the HIGH nibble.
        dh = 4'hF;
        dl = 4'hF;
        start_r = 1'b1;
        @(posedge clk);
        #1 start_r = 1'b0;
        repeat (9) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_idle("midreset");
        chk("midreset.thrsh", {7'd0, thr1}, 8'd0);
        chk("midreset.taps", {4'd0, hb21, hb01, lb21, lb01}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk_idle("midreset.after");
        frame_check(4'hA, 4'h3, 4, 1'b0, 1'b0, "after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_frame_seq.md
Name: serial_frame_seq

Overview:
Controller and data registers that feed the 7-way serial bit-select mux. On a start request it captures a high and a low nibble and computes a threshold flag. It then steps the mux select through a fixed frame (start bit, flag bit, high nibble, low nibble, stop bit), holding each symbol for a programmable number of clocks. It exports the register taps and flag that the mux consumes.

Parameters:
BIT_CYCLES, 4, clocks per transmitted symbol (legal range 2..255).
THRESH, 8'h80, unsigned compare value for the flag bit.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  frame request, sampled each rising edge.
data_h  in  4  high nibble, sampled when start is accepted.
data_l  in  4  low nibble, sampled when start is accepted.
muxsel  out  3  symbol select to the mux: 000 = 0, 001 = 1, 010 = thrsh, 011 = regh bit0, 100 = regl bit0.
thrsh  out  1  registered flag, 1 when {data_h,data_l} >= THRESH.
regh_b0  out  1  bit 0 of the internal high shift register.
regh_b2  out  1  bit 2 of the internal high shift register.
regl_b0  out  1  bit 0 of the internal low shift register.
regl_b2  out  1  bit 2 of the internal low shift register.
busy  out  1  high while a frame is in progress.
done  out  1  one-cycle pulse at frame completion.

Behaviour:
- Reset (rst_n = 0, asynchronous, any time including mid-frame):
  - State goes to IDLE.
  - muxsel = 001; busy = 0; done = 0; thrsh = 0.
  - regh = 0 and regl = 0, so all taps = 0.
  - Bit timer and bit index clear to 0.
- States: IDLE, START, FLAG, HIGH, LOW, STOP. All outputs are registered.
- muxsel per state: IDLE 001, START 000, FLAG 010, HIGH 011, LOW 100, STOP 001.
- Codes 101 and 110 are never driven by this block.
- Accept rule: start = 1 while in IDLE at edge k:
  - regh <= data_h; regl <= data_l.
  - thrsh <= ({data_h,data_l} >= THRESH), 8-bit unsigned compare.
  - State goes to START; busy = 1 from cycle k+1.
- Start is ignored while busy. Start in the same cycle that done is high is accepted, because the block is in IDLE.
- Symbol timing:
  - An internal timer counts 0..BIT_CYCLES-1 in every non-IDLE state.
  - The state advances when the timer reaches BIT_CYCLES-1; the timer then wraps to 0.
- HIGH state:
  - Lasts 4 symbols, tracked by a 2-bit index.
  - On the last clock of each HIGH symbol, regh shifts right by 1 with zero fill. Bits go out LSB first.
  - The transition to LOW happens after index 3 ends.
- LOW state: identical to HIGH, but shifts regl.
- regh is not shifted outside HIGH and regl is not shifted outside LOW. Taps reflect the live register contents.
- thrsh holds its value until the next accept.
- Frame length: 11 symbols = 11*BIT_CYCLES clocks.
  - busy is high in cycles k+1 .. k+11*BIT_CYCLES.
  - In cycle k+11*BIT_CYCLES+1 the state is IDLE, busy = 0 and done = 1 for exactly one cycle.
- Mux-output view: with the mux fed by this block, the serial line is 1 when idle, and 1 after the stop bit.

Test Plan:
1. Reset behaviour: assert rst_n = 0 mid-HIGH (cycle k+10) -> same cycle muxsel = 001, busy = 0, thrsh = 0, taps = 0. Release reset -> block stays IDLE until a start.
2. Nominal frame: BIT_CYCLES = 4, THRESH = 8'h80, data_h = 4'hA, data_l = 4'h3, start at edge k.
   - Required: thrsh = 1.
   - Mux line per 4-cycle symbol: 0,1,0,1,0,1,1,1,0,0,1.
   - busy over k+1..k+44; done only at k+45.
3. Threshold boundary: {data_h,data_l} = 8'h80 -> thrsh = 1. Value 8'h7F -> thrsh = 0, and the FLAG symbol drives 0.
4. Busy blocking: start pulses at k+5 and k+30 with different data -> ignored; the frame content stays that of the first capture; exactly one done pulse.
5. Back-to-back frames: hold start = 1 continuously -> a new frame begins at the done cycle, so busy drops for exactly one cycle between frames.
6. Tap check: data_h = 4'b0100, BIT_CYCLES = 2.
   - Before the first HIGH shift: regh_b2 = 1.
   - After two shifts: regh_b0 = 1 and regh_b2 = 0.
   - regl_b2 follows data_l[2] unchanged through HIGH.
